edge_filter_stream: RTL

- Parametrised streaming vertical-gradient edge detector for the RGB video pipeline; sits between the camera/frame-buffer source and the VGA sink.
- Successor to the fixed 320x240 RGB444 edge filter:
  - frame size, channel depth and threshold are parametrised.
  - Full Avalon-ST valid/ready handshake with stall support.
  - Border masking and a grey-level magnitude mode are added.
  - The mode is latched per frame.
- Line buffers hold KMAX-1 previous rows; a KMAX x KMAX window feeds a 3-stage pipelined multiply-accumulate.

---
 rtl/edge_filter_pkg.sv | 27 ++
 rtl/line_buffer.sv | 36 +++
 rtl/edge_filter_stream.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_filter_pkg.sv
// Shared types, kernel weights and the magnitude helper for the vertical-gradient edge filter.
package edge_filter_pkg;

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        K3_BIN = 2'd1,
        K5_BIN = 2'd2,
        K5_MAG = 2'd3
    } mode_e;

    typedef logic signed [2:0] wgt_t;

    // Index 0 is the oldest (top) row / leftmost column of the kernel.
    localparam wgt_t ROW_W3 [3] = '{3'sd1, 3'sd0, -3'sd1};
    localparam wgt_t COL_W3 [3] = '{3'sd1, 3'sd2, 3'sd1};
    localparam wgt_t ROW_W5 [5] = '{3'sd2, 3'sd1, 3'sd0, -3'sd1, -3'sd2};
    localparam wgt_t COL_W5 [5] = '{3'sd1, 3'sd1, 3'sd2, 3'sd1, 3'sd1};

    function automatic logic [31:0] sat_mag(input logic signed [31:0] g, input int unsigned bits);
        logic [31:0] a;
        logic [31:0] lim;
        a   = (g < 0) ? 32'(-g) : 32'(g);
        lim = (32'd1 << bits) - 32'd1;
        return (a > lim) ? lim : a;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Row delay line: dout is the word written DEPTH enabled cycles earlier.
// Latency: DEPTH enabled writes; read is combinational from the slot about to be overwritten.
// Backpressure: none internally; holds completely while en is low.
module line_buffer #(
    parameter int DEPTH = 320,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;

    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
        end
    end

endmodule

// File: rtl/edge_filter_stream.sv
// Streaming vertical-gradient edge detector (bypass / 3x3 / 5x5 binary / 5x5 grey magnitude).
// Latency: 3 enabled cycles from accepted input beat to valid_out; bubbles pass through as valid_out=0.
// Backpressure: whole datapath stalls on ready_in low; ready_out mirrors ready_in, outputs hold.
module edge_filter_stream
    import edge_filter_pkg::*;
#(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int CH_BITS = 4,
    parameter int KMAX    = 5,
    parameter int ACC_W   = CH_BITS + 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             mode,
    input  logic [ACC_W-2:0]       thresh,
    input  logic                   valid_in,
    input  logic                   startofpacket_in,
    input  logic                   endofpacket_in,
    input  logic [3*CH_BITS-1:0]   data_in,
    output logic                   ready_out,
    input  logic                   ready_in,
    output logic                   valid_out,
    output logic                   startofpacket_out,
    output logic                   endofpacket_out,
    output logic [3*CH_BITS-1:0]   data_out
);

    localparam int PIX_W  = 3 * CH_BITS;
    localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CH_MAX = (2 ** CH_BITS) - 1;
    localparam int OFS3   = KMAX - 3;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic [PIX_W-1:0]        pix_t;

    logic en;
    logic take;

    assign en        = ready_in;
    assign ready_out = ready_in;
    assign take      = valid_in & ready_in;

    // ---------------- position counters and per-frame mode latch ----------------
    logic [CW-1:0]    col_q, pos_col;
    logic [RW-1:0]    row_q, pos_row;
    mode_e            mode_q, mode_cur;
    logic [ACC_W-2:0] thresh_q, thr_cur;

    always_comb begin
        pos_col  = startofpacket_in ? '0 : col_q;
        pos_row  = startofpacket_in ? '0 : row_q;
        mode_cur = startofpacket_in ? mode_e'(mode) : mode_q;
        thr_cur  = startofpacket_in ? thresh : thresh_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q    <= '0;
            row_q    <= '0;
            mode_q   <= BYPASS;
            thresh_q <= '0;
        end else if (take) begin
            mode_q   <= mode_cur;
            thresh_q <= thr_cur;
            if (pos_col == CW'(IMG_W - 1)) begin
                col_q <= '0;
                row_q <= (pos_row == RW'(IMG_H - 1)) ? pos_row : pos_row + RW'(1);
            end else begin
                col_q <= pos_col + CW'(1);
                row_q <= pos_row;
            end
        end
    end

    // ---------------- line buffers and KMAX x KMAX window ----------------
    pix_t lb_in  [KMAX-1];
    pix_t lb_out [KMAX-1];
    pix_t tap    [KMAX];
    pix_t hist   [KMAX][KMAX-1];
    pix_t win    [KMAX][KMAX];

    genvar gk;
    generate
        for (gk = 0; gk < KMAX - 1; gk++) begin : g_lb
            if (gk == 0) begin : g_head
                assign lb_in[gk] = data_in;
            end else begin : g_chain
                assign lb_in[gk] = lb_out[gk-1];
            end
            line_buffer #(
                .DEPTH (IMG_W),
                .WIDTH (PIX_W)
            ) u_lb (
                .clk     (clk),
                .reset_n (reset_n),
                .en      (take),
                .din     (lb_in[gk]),
                .dout    (lb_out[gk])
            );
            // Window row KMAX-1 is the current row; row KMAX-2-gk is gk+1 rows back.
            assign tap[KMAX-2-gk] = lb_out[gk];
        end
    endgenerate

    assign tap[KMAX-1] = data_in;

    always_ff @(posedge clk) begin
        if (take) begin
            for (int r = 0; r < KMAX; r++) begin
                for (int c = 0; c < KMAX - 2; c++) begin
                    hist[r][c] <= hist[r][c+1];
                end
                hist[r][KMAX-2] <= tap[r];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < KMAX; r++) begin
            for (int c = 0; c < KMAX - 1; c++) begin
                win[r][c] = hist[r][c];
            end
            win[r][KMAX-1] = tap[r];
        end
    end

    // The 3x3 kernel sits in the bottom-right corner of the window; other taps weigh zero.
    function automatic wgt_t col_w(input mode_e m, input int c);
        if (m == K3_BIN) begin
            return (c >= OFS3) ? COL_W3[2'(c - OFS3)] : wgt_t'(0);
        end
        return COL_W5[3'(c)];
    endfunction

    function automatic wgt_t row_w(input mode_e m, input int r);
        if (m == K3_BIN) begin
            return (r >= OFS3) ? ROW_W3[2'(r - OFS3)] : wgt_t'(0);
        end
        return ROW_W5[3'(r)];
    endfunction

    // ---------------- S1: column-weighted row sums ----------------
    acc_t        rs_d [KMAX][3];
    logic        border_d;
    logic [31:0] k_lim;

    always_comb begin : s1_sum
        acc_t t;
        for (int r = 0; r < KMAX; r++) begin
            for (int ch = 0; ch < 3; ch++) begin
                t = '0;
                for (int c = 0; c < KMAX; c++) begin
                    t = t + acc_t'(col_w(mode_cur, c)) *
                            acc_t'({1'b0, win[r][c][ch*CH_BITS +: CH_BITS]});
                end
                rs_d[r][ch] = t;
            end
        end
        k_lim    = (mode_cur == K3_BIN) ? 32'd2 : 32'(KMAX - 1);
        border_d = (32'(pos_row) < k_lim) || (32'(pos_col) < k_lim);
    end

    logic             s1_vld, s1_sop, s1_eop, s1_border;
    pix_t             s1_pix;
    mode_e            s1_mode;
    logic [ACC_W-2:0] s1_thr;
    acc_t             s1_rs [KMAX][3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld    <= 1'b0;
            s1_sop    <= 1'b0;
            s1_eop    <= 1'b0;
            s1_border <= 1'b0;
            s1_pix    <= '0;
            s1_mode   <= BYPASS;
            s1_thr    <= '0;
            for (int r = 0; r < KMAX; r++) begin
                for (int ch = 0; ch < 3; ch++) begin
                    s1_rs[r][ch] <= '0;
                end
            end
        end else if (en) begin
            s1_vld    <= take;
            s1_sop    <= take & startofpacket_in;
            s1_eop    <= take & endofpacket_in;
            s1_border <= border_d;
            s1_pix    <= data_in;
            s1_mode   <= mode_cur;
            s1_thr    <= thr_cur;
            s1_rs     <= rs_d;
        end
    end

    // ---------------- S2: row weighting, upper and lower partial sums ----------------
    acc_t pa_d [3];
    acc_t pb_d [3];

    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            pa_d[ch] = '0;
            pb_d[ch] = '0;
            for (int r = 0; r < KMAX; r++) begin
                if (r <= KMAX / 2) begin
                    pa_d[ch] = pa_d[ch] + acc_t'(row_w(s1_mode, r)) * s1_rs[r][ch];
                end else begin
                    pb_d[ch] = pb_d[ch] + acc_t'(row_w(s1_mode, r)) * s1_rs[r][ch];
                end
            end
        end
    end

    logic             s2_vld, s2_sop, s2_eop, s2_border;
    pix_t             s2_pix;
    mode_e            s2_mode;
    logic [ACC_W-2:0] s2_thr;
    acc_t             s2_pa [3];
    acc_t             s2_pb [3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_vld    <= 1'b0;
            s2_sop    <= 1'b0;
            s2_eop    <= 1'b0;
            s2_border <= 1'b0;
            s2_pix    <= '0;
            s2_mode   <= BYPASS;
            s2_thr    <= '0;
            for (int ch = 0; ch < 3; ch++) begin
                s2_pa[ch] <= '0;
                s2_pb[ch] <= '0;
            end
        end else if (en) begin
            s2_vld    <= s1_vld;
            s2_sop    <= s1_sop;
            s2_eop    <= s1_eop;
            s2_border <= s1_border;
            s2_pix    <= s1_pix;
            s2_mode   <= s1_mode;
            s2_thr    <= s1_thr;
            s2_pa     <= pa_d;
            s2_pb     <= pb_d;
        end
    end

    // ---------------- S3: total, magnitude and output selection ----------------
    acc_t             g_sum [3];
    logic [ACC_W-2:0] mag   [3];
    logic [ACC_W-2:0] mag_q [3];
    logic             hit;
    pix_t             mag_pix;
    pix_t             res_d;

    always_comb begin
        hit     = 1'b0;
        mag_pix = '0;
        for (int ch = 0; ch < 3; ch++) begin
            g_sum[ch] = s2_pa[ch] + s2_pb[ch];
            mag[ch]   = (ACC_W-1)'(sat_mag(32'(g_sum[ch]), ACC_W - 1));
            mag_q[ch] = mag[ch] >> 2;
            hit       = hit | (mag[ch] >= s2_thr);
            mag_pix[ch*CH_BITS +: CH_BITS] = (mag_q[ch] > (ACC_W-1)'(CH_MAX)) ?
                                             '1 : CH_BITS'(mag_q[ch]);
        end
        if (s2_mode == BYPASS) begin
            res_d = s2_pix;
        end else if (s2_border) begin
            res_d = '0;
        end else if (s2_mode == K5_MAG) begin
            res_d = mag_pix;
        end else begin
            res_d = hit ? '1 : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_out         <= 1'b0;
            startofpacket_out <= 1'b0;
            endofpacket_out   <= 1'b0;
            data_out          <= '0;
        end else if (en) begin
            valid_out         <= s2_vld;
            startofpacket_out <= s2_sop;
            endofpacket_out   <= s2_eop;
            data_out          <= res_d;
        end
    end

endmodule
